// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and receiver/transmitter state encodings.
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, single pulse per frame on po_flag or frame_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int UART_BPS = 'd9600,
  parameter int CLK_FREQ = 'd50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  // Baud timing is derived here so each instance can run at its own rate; legal range 4..65535.
  localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [15:0] BAUD_LAST    = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] SAMPLE_PT    = 16'(BAUD_CNT_MAX / 2 - 1);

  logic        rx_meta;
  logic        rx_s;
  logic        rx_hist;
  uart_state_e state;
  uart_state_e state_next;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        start_det;
  logic        sample;
  logic        bit_clr;
  logic        shift_en;
  logic        good_stop;
  logic        bad_stop;

  // Two-flop synchroniser plus a history flop for edge detection; resets to the idle line level.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta <= IDLE_LEVEL;
      rx_s    <= IDLE_LEVEL;
      rx_hist <= IDLE_LEVEL;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_hist <= rx_s;
    end
  end

  assign start_det = (state == IDLE) && rx_hist && !rx_s;
  assign sample    = (state != IDLE) && (baud_cnt == SAMPLE_PT);

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-sample strobes; STOP leaves at mid-bit so a back-to-back start edge is seen.
  always_comb begin
    state_next = state;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      IDLE: begin
        if (start_det) begin
          state_next = START;
        end
      end
      START: begin
        if (sample) begin
          if (rx_s == START_LEVEL) begin
            state_next = DATA;
            bit_clr    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (sample) begin
          state_next = IDLE;
          if (rx_s == STOP_LEVEL) begin
            good_stop = 1'b1;
          end else begin
            bad_stop = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Baud counter: parked at zero in IDLE, free-running with wrap for the rest of the frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      baud_cnt <= 16'd0;
    end else if (state == IDLE) begin
      baud_cnt <= 16'd0;
    end else if (baud_cnt == BAUD_LAST) begin
      baud_cnt <= 16'd0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // Data bits land LSB first at the position given by bit_cnt.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
    end else if (bit_clr) begin
      bit_cnt <= 3'd0;
    end else if (shift_en) begin
      shift_reg[bit_cnt] <= rx_s;
      bit_cnt            <= bit_cnt + 3'd1;
    end
  end

  // Registered result pulses; po_data only changes on a correctly framed byte.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      po_data   <= 8'h00;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      po_flag   <= good_stop;
      frame_err <= bad_stop;
      if (good_stop) begin
        po_data <= shift_reg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: randomized and directed 8N1 frames, scoreboard-checked by a pulse monitor.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  UART_BPS     = 115200;
  localparam int  CLK_FREQ     = 50_000_000;
  localparam int  CLK_NS       = 20;
  localparam int  BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam real BIT_NS       = BAUD_CNT_MAX * CLK_NS;
  localparam int  LAT_NOMINAL  = 2 + 9 * BAUD_CNT_MAX + BAUD_CNT_MAX / 2;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         chk_lat;
    realtime    t0;
  } exp_t;

  logic       sys_clk;
  logic       sys_rst;
  logic       rx;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_po_data = 8'h00;
  int         lat;

  uart_rx #(
    .UART_BPS(UART_BPS),
    .CLK_FREQ(CLK_FREQ)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx       (rx),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .frame_err(frame_err)
  );

  // Free-running 50 MHz system clock.
  initial sys_clk = 1'b0;
  always #(CLK_NS / 2) sys_clk = ~sys_clk;

  // Hard time limit so the run always ends.
  initial begin
    #4_000_000;
    $display("[TB] FAIL watchdog expired queue=%0d", exp_q.size());
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge sys_clk);
  endtask

  // Reset in the middle of a frame: outputs must clear immediately, model's last byte returns to zero.
  task automatic pulseReset();
    sys_rst = 1'b1;
    #5;
    checkOutput("rst_po_data", {24'd0, po_data}, 32'h00);
    checkOutput("rst_po_flag", {31'd0, po_flag}, 32'h0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'h0);
    rx = 1'b1;
    exp_po_data = 8'h00;
    #60;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Serialise one frame with the transmitter clock ppt parts-per-thousand off nominal.
  task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input int ppt,
                               input bit chk_lat, input int abort_bit);
    real  bit_t;
    exp_t e;
    bit   aborted;
    bit_t   = BIT_NS * (1000.0 + ppt) / 1000.0;
    aborted = 1'b0;
    rx      = 1'b0;
    if (abort_bit < 0) begin
      e.is_err  = !stop_bit;
      e.data    = data;
      e.chk_lat = chk_lat;
      e.t0      = $realtime;
      exp_q.push_back(e);
    end
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == abort_bit) begin
        #(bit_t / 2.0);
        pulseReset();
        aborted = 1'b1;
        break;
      end
      #(bit_t);
    end
    if (!aborted) begin
      rx = stop_bit;
      #(bit_t);
      rx = 1'b1;
    end
  endtask

  // Monitor: every output pulse pops one expectation and is compared against it.
  always @(negedge sys_clk) begin
    if (!sys_rst && (po_flag || frame_err)) begin
      checkOutput("flag_err_exclusive", {31'd0, po_flag & frame_err}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse actual flag=%0b err=%0b data=0x%0h required=no pulse",
                 po_flag, frame_err, po_data);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pulse_kind_err", {31'd0, frame_err}, {31'd0, mon_e.is_err});
        if (po_flag && !mon_e.is_err) begin
          checkOutput("po_data", {24'd0, po_data}, {24'd0, mon_e.data});
          exp_po_data = mon_e.data;
          if (mon_e.chk_lat) begin
            lat = int'(($realtime - mon_e.t0) / CLK_NS);
            checks++;
            if (lat < LAT_NOMINAL - 2 || lat > LAT_NOMINAL + 2) begin
              failures++;
              $display("[TB] FAIL latency actual=%0d required=%0d+-2", lat, LAT_NOMINAL);
            end
          end
        end
        if (frame_err) begin
          checkOutput("po_data_held", {24'd0, po_data}, {24'd0, exp_po_data});
        end
      end
    end
  end

  // Directed scenarios followed by a few random frames.
  initial begin
    logic [7:0] rdata;
    int         rppt;
    bit         rstop;
    sys_rst = 1'b1;
    rx      = 1'b1;
    idle(5);
    checkOutput("reset_po_data", {24'd0, po_data}, 32'h00);
    checkOutput("reset_po_flag", {31'd0, po_flag}, 32'h0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'h0);
    sys_rst = 1'b0;
    idle(10);

    $display("[TB] single frame 0x55 with latency check");
    applyStimulus(8'h55, 1'b1, 0, 1'b1, -1);
    idle(20);

    $display("[TB] back-to-back 0xA3, 0x0F");
    applyStimulus(8'hA3, 1'b1, 0, 1'b0, -1);
    applyStimulus(8'h0F, 1'b1, 0, 1'b0, -1);
    idle(20);

    $display("[TB] short low glitch then 0x81");
    rx = 1'b0;
    idle(int'($urandom_range(150, 20)));
    rx = 1'b1;
    idle(BAUD_CNT_MAX);
    applyStimulus(8'h81, 1'b1, 0, 1'b0, -1);
    idle(20);

    $display("[TB] 0x12 then 0xFF with bad stop bit");
    applyStimulus(8'h12, 1'b1, 0, 1'b0, -1);
    idle(20);
    applyStimulus(8'hFF, 1'b0, 0, 1'b0, -1);
    idle(20);

    $display("[TB] reset during data bit 4, then 0x3C");
    applyStimulus(8'h3C, 1'b1, 0, 1'b0, 4);
    idle(BAUD_CNT_MAX);
    applyStimulus(8'h3C, 1'b1, 0, 1'b0, -1);
    idle(20);

    $display("[TB] transmitter clock +-2 percent");
    applyStimulus(8'h00, 1'b1, 20, 1'b0, -1);
    idle(20);
    applyStimulus(8'hFF, 1'b1, -20, 1'b0, -1);
    idle(20);
    applyStimulus(8'hC5, 1'b1, 20, 1'b0, -1);
    idle(20);
    applyStimulus(8'hC5, 1'b1, -20, 1'b0, -1);
    idle(20);

    $display("[TB] random frames");
    for (int n = 0; n < 3; n++) begin
      rdata = 8'($urandom);
      rppt  = int'($urandom_range(40)) - 20;
      rstop = ($urandom_range(3) != 0);
      applyStimulus(rdata, rstop, rppt, 1'b0, -1);
      idle(int'($urandom_range(40, 5)));
    end

    idle(2 * BAUD_CNT_MAX);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
